// File: rtl/apb_uart_fifo.sv
// 16550-subset UART on APB: TX/RX byte FIFOs, programmable divisor, 8N1 serial,
// line-status flags, loopback and a registered level interrupt.

module apb_uart_fifo_buf #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot the push lands in, so push+pop is legal when full.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end
endmodule

module apb_uart_fifo #(
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter logic [15:0] DIV_RESET = 16'd1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    input  logic [3:0]  pstrb_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic        tx_o,
    input  logic        rx_i,
    output logic        irq_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

    logic [7:0]  lcr_q, scr_q;
    logic [3:0]  ier_q;
    logic [4:0]  mcr_q;
    logic [15:0] div_q, div_eff;
    logic        fifo_en_q, oe_q, fe_q, irq_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_line;

    logic        strb_ok, access, wr_en, rd_en, dlab, unused_addr;
    logic [1:0]  lane;
    logic [2:0]  idx;
    logic [7:0]  wbyte, rbyte, lsr, iir;
    logic [3:0]  iid;
    logic        thr_wr, tx_push, rx_pop, lsr_rd, fcr_wr, oe_set, fe_set;
    logic        dr, thre, temt;

    logic        tx_empty, tx_full, tx_pop, tx_ser;
    logic [7:0]  tx_head;
    logic        rx_empty, rx_full, rx_push;
    logic [7:0]  rx_head;

    uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_bdiv_q, tx_bdiv_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_bdiv_q, rx_bdiv_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;

    always_comb begin
        strb_ok = 1'b1;
        lane    = 2'd0;
        case (pstrb_i)
            4'b0001: lane = 2'd0;
            4'b0010: lane = 2'd1;
            4'b0100: lane = 2'd2;
            4'b1000: lane = 2'd3;
            default: strb_ok = 1'b0;
        endcase
    end

    assign unused_addr = ^paddr_i[31:3];
    assign idx     = paddr_i[2:0] + {1'b0, lane};
    assign wbyte   = pwdata_i[{lane, 3'b000} +: 8];
    assign access  = psel_i & penable_i;
    assign wr_en   = access & pwrite_i & strb_ok;
    assign rd_en   = access & ~pwrite_i & strb_ok;
    assign dlab    = lcr_q[7];
    assign thr_wr  = wr_en & (idx == 3'd0) & ~dlab;
    assign tx_push = thr_wr & ~tx_full;
    assign rx_pop  = rd_en & (idx == 3'd0) & ~dlab;
    assign lsr_rd  = rd_en & (idx == 3'd5);
    assign fcr_wr  = wr_en & (idx == 3'd2);
    assign oe_set  = rx_push & rx_full & ~rx_pop;

    assign pready_o  = 1'b1;
    assign pslverr_o = access & (~strb_ok | (thr_wr & tx_full));
    assign div_eff   = (div_q == 16'd0) ? 16'd1 : div_q;

    assign dr   = ~rx_empty;
    assign thre = tx_empty;
    assign temt = tx_empty & (tx_state_q == ST_IDLE);
    assign lsr  = {1'b0, temt, thre, 1'b0, fe_q, 1'b0, oe_q, dr};
    assign iir  = {fifo_en_q, fifo_en_q, 2'b00, iid};

    always_comb begin
        if (ier_q[2] && (oe_q || fe_q)) iid = 4'h6;
        else if (ier_q[0] && dr)        iid = 4'h4;
        else if (ier_q[1] && thre)      iid = 4'h2;
        else                            iid = 4'h1;
    end

    always_comb begin
        rbyte = 8'h00;
        case (idx)
            3'd0: rbyte = dlab ? div_q[7:0] : (rx_empty ? 8'h00 : rx_head);
            3'd1: rbyte = dlab ? div_q[15:8] : {4'h0, ier_q};
            3'd2: rbyte = iir;
            3'd3: rbyte = lcr_q;
            3'd4: rbyte = {3'b000, mcr_q};
            3'd5: rbyte = lsr;
            3'd7: rbyte = scr_q;
            default: rbyte = 8'h00;
        endcase
    end

    assign prdata_o = rd_en ? ({24'h0, rbyte} << {lane, 3'b000}) : 32'h0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lcr_q <= '0; ier_q <= '0; mcr_q <= '0; scr_q <= '0;
            div_q <= DIV_RESET; fifo_en_q <= 1'b0;
            oe_q  <= 1'b0; fe_q <= 1'b0; irq_q <= 1'b0;
            rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
        end else begin
            if (wr_en) begin
                case (idx)
                    3'd0: if (dlab) div_q[7:0] <= wbyte;
                    3'd1: if (dlab) div_q[15:8] <= wbyte; else ier_q <= wbyte[3:0];
                    3'd2: fifo_en_q <= wbyte[0];
                    3'd3: lcr_q <= wbyte;
                    3'd4: mcr_q <= wbyte[4:0];
                    3'd7: scr_q <= wbyte;
                    default: ;
                endcase
            end
            oe_q      <= (oe_q & ~lsr_rd) | oe_set;
            fe_q      <= (fe_q & ~lsr_rd) | fe_set;
            irq_q     <= ~iid[0];
            rx_s1_q   <= rx_line;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign irq_o = irq_q;

    apb_uart_fifo_buf #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(fcr_wr & wbyte[2]),
        .push_i(tx_push), .pop_i(tx_pop), .wdata_i(wbyte),
        .rdata_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
    );

    apb_uart_fifo_buf #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(fcr_wr & wbyte[1]),
        .push_i(rx_push), .pop_i(rx_pop), .wdata_i(rx_sh_q),
        .rdata_o(rx_head), .empty_o(rx_empty), .full_o(rx_full)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= ST_IDLE; tx_cnt_q <= '0; tx_bdiv_q <= 16'd1; tx_bit_q <= '0;
            rx_state_q <= ST_IDLE; rx_cnt_q <= '0; rx_bdiv_q <= 16'd1; rx_bit_q <= '0;
        end else begin
            tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_bdiv_q <= tx_bdiv_d; tx_bit_q <= tx_bit_d;
            rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bdiv_q <= rx_bdiv_d; rx_bit_q <= rx_bit_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tx_sh_q <= tx_sh_d;
        rx_sh_q <= rx_sh_d;
    end

    // Each bit latches the divisor at its boundary, so a new divisor starts with the next bit.
    always_comb begin
        tx_state_d = tx_state_q; tx_cnt_d = tx_cnt_q + 16'd1; tx_bdiv_d = tx_bdiv_q;
        tx_bit_d = tx_bit_q; tx_sh_d = tx_sh_q; tx_pop = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop = 1'b1; tx_sh_d = tx_head; tx_bdiv_d = div_eff; tx_state_d = ST_START;
                end
            end
            ST_START: if (tx_cnt_q == tx_bdiv_q - 16'd1) begin
                tx_cnt_d = '0; tx_bdiv_d = div_eff; tx_bit_d = '0; tx_state_d = ST_DATA;
            end
            ST_DATA: if (tx_cnt_q == tx_bdiv_q - 16'd1) begin
                tx_cnt_d = '0; tx_bdiv_d = div_eff;
                if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                else begin
                    tx_bit_d = tx_bit_q + 3'd1; tx_sh_d = {1'b0, tx_sh_q[7:1]};
                end
            end
            ST_STOP: if (tx_cnt_q == tx_bdiv_q - 16'd1) begin
                tx_cnt_d = '0; tx_bdiv_d = div_eff;
                if (!tx_empty) begin
                    tx_pop = 1'b1; tx_sh_d = tx_head; tx_state_d = ST_START;
                end else tx_state_d = ST_IDLE;
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_ser = 1'b1;
        case (tx_state_q)
            ST_START: tx_ser = 1'b0;
            ST_DATA:  tx_ser = tx_sh_q[0];
            default:  tx_ser = 1'b1;
        endcase
    end

    assign tx_o    = tx_ser | mcr_q[4];
    assign rx_line = mcr_q[4] ? tx_ser : rx_i;

    // rx_cnt counts from 1 so the start check lands at mid-bit and later samples every bdiv cycles.
    always_comb begin
        rx_state_d = rx_state_q; rx_cnt_d = rx_cnt_q + 16'd1; rx_bdiv_d = rx_bdiv_q;
        rx_bit_d = rx_bit_q; rx_sh_d = rx_sh_q; rx_push = 1'b0; fe_set = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = 16'd1;
                if (rx_prev_q && !rx_s2_q) begin
                    rx_bdiv_d = div_eff; rx_state_d = ST_START;
                end
            end
            ST_START: if (rx_cnt_q >= {1'b0, rx_bdiv_q[15:1]}) begin
                rx_cnt_d = 16'd1;
                if (rx_s2_q) rx_state_d = ST_IDLE;
                else begin
                    rx_bdiv_d = div_eff; rx_bit_d = '0; rx_state_d = ST_DATA;
                end
            end
            ST_DATA: if (rx_cnt_q >= rx_bdiv_q) begin
                rx_cnt_d = 16'd1; rx_bdiv_d = div_eff; rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                else rx_bit_d = rx_bit_q + 3'd1;
            end
            ST_STOP: if (rx_cnt_q >= rx_bdiv_q) begin
                rx_push = 1'b1; fe_set = ~rx_s2_q; rx_state_d = ST_IDLE;
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed bench for apb_uart_fifo: register access, serial TX/RX framing,
// FIFO limits, loopback, line-status flags and interrupt timing.

module tb_apb_uart_fifo;
    logic        clk = 1'b0;
    logic        rst, psel, penable, pwrite, rx;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr, tx, irq;
    int          n_tests = 0;
    int          n_fail  = 0;

    apb_uart_fifo #(.TX_DEPTH(16), .RX_DEPTH(16), .DIV_RESET(16'd1)) dut (
        .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata),
        .pready_o(pready), .pslverr_o(pslverr), .tx_o(tx), .rx_i(rx), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pstrb = s; pwdata = d;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk); err = pslverr;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [31:0] a, input logic [3:0] s, output logic [31:0] d, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pstrb = s;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk); d = prdata; err = pslverr;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input logic [2:0] i, input logic [7:0] b);
        logic e;
        apb_wr({29'd0, i}, 4'b0001, {24'd0, b}, e);
    endtask

    task automatic rdchk(input string tag, input logic [2:0] i, input logic [7:0] exp);
        logic [31:0] d;
        logic        e;
        apb_rd({29'd0, i}, 4'b0001, d, e);
        check(tag, d, {24'd0, exp});
    endtask

    task automatic set_div(input logic [15:0] dv);
        wr(3, 8'h80); wr(0, dv[7:0]); wr(1, dv[15:8]); wr(3, 8'h03);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (8) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [9:0]  frame;
        int          errs;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_slverr", {31'd0, pslverr}, 32'd0);
        apb_rd(32'd4, 4'b0010, d, e);
        check("rst_lsr_lane1", d, 32'h0000_6000);
        rdchk("rst_iir", 2, 8'h01);

        // D=4, one 0xA5 frame sampled mid-bit
        wr(3, 8'h80); wr(0, 8'h04); wr(1, 8'h00);
        rdchk("dll_readback", 0, 8'h04);
        wr(3, 8'h03);
        rdchk("lcr_readback", 3, 8'h03);
        wr(0, 8'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), {31'd0, tx}, {31'd0, frame[i]});
            repeat (4) @(posedge clk);
            #1;
        end
        rdchk("temt_after_frame", 5, 8'h60);

        // D=1000: TX FIFO capacity and overflow error
        set_div(16'd1000);
        errs = 0;
        for (int i = 0; i < 17; i++) begin
            apb_wr(32'd0, 4'b0001, i, e);
            if (e) errs++;
        end
        check("thr_17_accepted", errs, 32'd0);
        apb_wr(32'd0, 4'b0001, 32'h55, e);
        check("thr_full_slverr", {31'd0, e}, 32'd1);
        rdchk("lsr_tx_busy", 5, 8'h00);
        wr(2, 8'h04);
        rdchk("lsr_tx_flushed", 5, 8'h20);
        set_div(16'd2);
        repeat (1200) @(posedge clk);
        #1;
        rdchk("lsr_inflight_done", 5, 8'h60);

        // Loopback at D=2
        wr(4, 8'h10); wr(1, 8'h01);
        wr(0, 8'h3C); wr(0, 8'hC3);
        check("lb_tx_forced_high", {31'd0, tx}, 32'd1);
        check("lb_irq_before", {31'd0, irq}, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        check("lb_irq_first_byte", {31'd0, irq}, 32'd1);
        rdchk("lb_lsr_mid", 5, 8'h21);
        repeat (20) @(posedge clk);
        #1;
        rdchk("lb_rbr0", 0, 8'h3C);
        check("lb_irq_one_left", {31'd0, irq}, 32'd1);
        rdchk("lb_rbr1", 0, 8'hC3);
        check("lb_irq_held_1cyc", {31'd0, irq}, 32'd1);
        @(posedge clk); #1;
        check("lb_irq_fall", {31'd0, irq}, 32'd0);
        rdchk("lb_lsr_empty", 5, 8'h60);
        rdchk("lb_rbr_empty", 0, 8'h00);

        // External rx_i at D=8: framing error, good frame, glitch
        wr(4, 8'h00); wr(1, 8'h00);
        set_div(16'd8);
        send_rx(8'h5A, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        rdchk("rx_fe_set", 5, 8'h69);
        rdchk("rx_fe_cleared", 5, 8'h61);
        rdchk("rx_fe_byte", 0, 8'h5A);
        send_rx(8'h81, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        rdchk("rx_good_lsr", 5, 8'h61);
        rdchk("rx_good_byte", 0, 8'h81);
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        rdchk("rx_glitch_ignored", 5, 8'h60);

        // Overrun: 17 loopback bytes into a 16-entry RX FIFO
        set_div(16'd2);
        wr(4, 8'h10); wr(1, 8'h04); wr(2, 8'h01);
        for (int i = 0; i < 17; i++) wr(0, 8'h10 + 8'(i));
        repeat (400) @(posedge clk);
        #1;
        rdchk("ovr_iir", 2, 8'hC6);
        check("ovr_irq", {31'd0, irq}, 32'd1);
        rdchk("ovr_lsr_oe", 5, 8'h63);
        rdchk("ovr_lsr_cleared", 5, 8'h61);
        rdchk("ovr_first_byte", 0, 8'h10);
        wr(2, 8'h03);
        rdchk("rx_flush_dr0", 5, 8'h60);
        rdchk("iir_none_fifo", 2, 8'hC1);

        // Byte lanes and non-one-hot strobes
        apb_wr(32'd4, 4'b1000, 32'h7700_0000, e);
        check("scr_lane3_err", {31'd0, e}, 32'd0);
        apb_rd(32'd4, 4'b1000, d, e);
        check("scr_lane3_rd", d, 32'h7700_0000);
        apb_wr(32'd7, 4'b0011, 32'h0000_FFFF, e);
        check("bad_strb_wr_err", {31'd0, e}, 32'd1);
        apb_rd(32'd7, 4'b0011, d, e);
        check("bad_strb_rd_err", {31'd0, e}, 32'd1);
        check("bad_strb_rd_data", d, 32'd0);
        rdchk("scr_unchanged", 7, 8'h77);

        // Reset during a frame
        wr(4, 8'h00);
        wr(0, 8'h00);
        @(posedge clk); #1;
        check("mid_frame_start", {31'd0, tx}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        rdchk("post_rst_lsr", 5, 8'h60);
        rdchk("post_rst_lcr", 3, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
